rng_freq_test: RTL and testbench

RNG_FREQ_TEST -- requirements
Module: rng_freq_test

---
 rtl/rng_freq_test.sv | 159 +++++++++++++++
 tb/tb_rng_freq_test.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rng_freq_test.sv
// Monobit frequency test over WORDS 32-bit samples, with an optional runs count.
// Define RUNS_TEST_EN to compile in runs counting and the runs_count port.
module rng_freq_test #(
    parameter int WORDS = 1024,
    parameter int LIMIT = 256,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          req,
    output logic          busy,
    output logic          done,
`ifdef RUNS_TEST_EN
    output logic [CW-1:0] runs_count,
`endif
    output logic [CW-1:0] ones_count,
    output logic          pass
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EVAL, S_DONE} state_t;

    localparam logic [CW:0]   EXP_ONES = (CW+1)'(WORDS * 16);
    localparam logic [CW:0]   LIM      = (CW+1)'(LIMIT);
    localparam logic [CW-1:0] LAST     = CW'(WORDS - 1);

    function automatic logic [5:0] popcnt(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [CW-1:0] ones_acc_q, ones_acc_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [CW-1:0] ones_count_q, ones_count_d;
    logic          accept;
    logic signed [CW:0] delta;
    logic [CW:0]   abs_diff;
`ifdef RUNS_TEST_EN
    logic [CW-1:0] runs_acc_q, runs_acc_d;
    logic [CW-1:0] runs_count_q, runs_count_d;
    logic          prev_bit_q, prev_bit_d;
    logic          first_q, first_d;
    logic [5:0]    trans;
`endif

    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        ones_acc_d   = ones_acc_q;
        word_cnt_d   = word_cnt_q;
        ones_count_d = ones_count_q;
`ifdef RUNS_TEST_EN
        runs_acc_d   = runs_acc_q;
        runs_count_d = runs_count_q;
        prev_bit_d   = prev_bit_q;
        first_d      = first_q;
        // Word-internal transitions plus the seam to the previous word.
        trans = popcnt({1'b0, in_data[31:1] ^ in_data[30:0]})
              + 6'(!first_q && (prev_bit_q != in_data[0]));
`endif
        accept   = (state_q == S_ACCUM) && req_q && in_valid;
        delta    = $signed({1'b0, ones_acc_q}) - $signed(EXP_ONES);
        abs_diff = delta[CW] ? (CW+1)'(-delta) : (CW+1)'(delta);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d    = S_ACCUM;
                    ones_acc_d = '0;
                    word_cnt_d = '0;
`ifdef RUNS_TEST_EN
                    runs_acc_d = '0;
                    prev_bit_d = 1'b0;
                    first_d    = 1'b1;
`endif
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    ones_acc_d = ones_acc_q + CW'(popcnt(in_data));
                    word_cnt_d = word_cnt_q + 1'b1;
`ifdef RUNS_TEST_EN
                    runs_acc_d = runs_acc_q + CW'(trans);
                    prev_bit_d = in_data[31];
                    first_d    = 1'b0;
`endif
                    if (word_cnt_q == LAST) state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d      = S_DONE;
                ones_count_d = ones_acc_q;
                pass_d       = (abs_diff <= LIM);
`ifdef RUNS_TEST_EN
                runs_count_d = runs_acc_q + 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        req_d  = (state_d == S_ACCUM);
        busy_d = (state_d == S_ACCUM) || (state_d == S_EVAL);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            ones_acc_q   <= '0;
            word_cnt_q   <= '0;
            ones_count_q <= '0;
`ifdef RUNS_TEST_EN
            runs_acc_q   <= '0;
            runs_count_q <= '0;
            prev_bit_q   <= 1'b0;
            first_q      <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            ones_acc_q   <= ones_acc_d;
            word_cnt_q   <= word_cnt_d;
            ones_count_q <= ones_count_d;
`ifdef RUNS_TEST_EN
            runs_acc_q   <= runs_acc_d;
            runs_count_q <= runs_count_d;
            prev_bit_q   <= prev_bit_d;
            first_q      <= first_d;
`endif
        end
    end

    assign req        = req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign ones_count = ones_count_q;
`ifdef RUNS_TEST_EN
    assign runs_count = runs_count_q;
`endif

endmodule

// File: tb/tb_rng_freq_test.sv
// Directed bench for rng_freq_test with WORDS=4, LIMIT=8, CW=16.
// Runs-count checks apply when RUNS_TEST_EN is defined.
module tb_rng_freq_test;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        req;
    logic        busy;
    logic        done;
    logic [15:0] ones_count;
    logic        pass;
`ifdef RUNS_TEST_EN
    logic [15:0] runs_count;
`endif

    int total;
    int bad;
    logic [31:0] words [4];
    logic [15:0] prev_ones;

    rng_freq_test #(
        .WORDS(4),
        .LIMIT(8),
        .CW   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .req       (req),
        .busy      (busy),
        .done      (done),
`ifdef RUNS_TEST_EN
        .runs_count(runs_count),
`endif
        .ones_count(ones_count),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_test(input int gap, input bit poke,
                            input logic [15:0] exp_ones,
                            input logic exp_pass,
                            input logic [15:0] exp_runs);
        do_start();
        chk("req_on", 32'(req), 32'd1);
        chk("busy_on", 32'(busy), 32'd1);
        chk("ones_hold", 32'(ones_count), 32'(prev_ones));
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
                chk("req_gap", 32'(req), 32'd1);
                chk("done_gap", 32'(done), 32'd0);
            end
            if (poke && i == 2) start = 1'b1;
            in_valid = 1'b1;
            in_data  = words[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start    = 1'b0;
        end
        chk("req_drop", 32'(req), 32'd0);
        chk("eval_nodone", 32'(done), 32'd0);
        chk("eval_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("ones", 32'(ones_count), 32'(exp_ones));
        chk("pass", 32'(pass), 32'(exp_pass));
`ifdef RUNS_TEST_EN
        chk("runs", 32'(runs_count), 32'(exp_runs));
`else
        if (exp_runs == 16'hFFFF) $display("note: runs unused");
`endif
        @(posedge clk);
        #1;
        chk("done_drop", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("ones_keep", 32'(ones_count), 32'(exp_ones));
        prev_ones = exp_ones;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        prev_ones = '0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_ones", 32'(ones_count), 32'd0);
`ifdef RUNS_TEST_EN
        chk("rst_runs", 32'(runs_count), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_req", 32'(req), 32'd0);

        foreach (words[i]) words[i] = 32'h0000_0000;
        run_test(0, 1'b0, 16'd0, 1'b0, 16'd1);

        foreach (words[i]) words[i] = 32'h5555_5555;
        run_test(0, 1'b0, 16'd64, 1'b1, 16'd128);

        foreach (words[i]) words[i] = 32'hFFFF_0000;
        run_test(3, 1'b0, 16'd64, 1'b1, 16'd8);

        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'hFFFF_FFFF;
        words[2] = 32'h0000_000F;
        words[3] = 32'h0000_0000;
        run_test(1, 1'b1, 16'd68, 1'b1, 16'd2);

        // Abort after two accepts, then a clean restart.
        do_start();
        in_valid = 1'b1;
        in_data  = 32'h0000_00FF;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req", 32'(req), 32'd0);
        chk("abort_ones", 32'(ones_count), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("abort_nodone", 32'(done), 32'd0);
        end
        prev_ones = '0;
        foreach (words[i]) words[i] = 32'h0000_00FF;
        run_test(0, 1'b0, 16'd32, 1'b0, 16'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
